// File: rtl/txt_buffer.sv
// txt_buffer: COLS x ROWS character RAM with a registered read port and a command
// port that writes single characters, prints decimal numbers, or clears the screen.
module txt_buffer #(
    parameter int COLS       = 16,
    parameter int ROWS       = 16,
    parameter int DIGITS     = 3,
    parameter int NUM_W      = 10,
    parameter int LEAD_BLANK = 1,
    localparam int COL_W     = $clog2(COLS),
    localparam int ROW_W     = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [COL_W-1:0] rd_x,
    input  logic [ROW_W-1:0] rd_y,
    output logic [6:0]       char_code,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [COL_W-1:0] cmd_x,
    input  logic [ROW_W-1:0] cmd_y,
    input  logic [6:0]       cmd_char,
    input  logic [NUM_W-1:0] cmd_num,
    output logic             busy
);
    localparam int AW      = ROW_W + COL_W;
    localparam int CELLS   = COLS * ROWS;
    localparam int IW      = $clog2(CELLS);
    localparam int BCD_W   = 4 * DIGITS;
    localparam int MAX_NUM = 10 ** DIGITS - 1;
    localparam int CNT_W   = $clog2(NUM_W + DIGITS + 1);
    localparam int XW      = COL_W + $clog2(DIGITS + 1) + 1;
    localparam logic [AW-1:0]  COLS_A    = AW'(COLS);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(CELLS - 1);
    localparam logic [XW-1:0]  COLS_X    = XW'(COLS);
    localparam logic [ROW_W:0] ROWS_Y    = (ROW_W + 1)'(ROWS);

    typedef enum logic [1:0] {IDLE, CLEAR, CONV, EMIT} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [XW-1:0]    col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             row_ok_q, row_ok_d;
    logic             seen_q, seen_d;
    logic [6:0]       char_q, char_d;
    logic [6:0]       mem_q [CELLS];

    logic             we;
    logic [AW-1:0]    waddr;
    logic [6:0]       wdata;
    logic             accept;
    logic [BCD_W-1:0] bcd_adj;
    logic [3:0]       digit;
    logic             blank;

    function automatic logic [AW-1:0] cell_addr(logic [ROW_W-1:0] y, logic [XW-1:0] x);
        return AW'(y) * COLS_A + AW'(x);
    endfunction

    assign cmd_ready = rst_n && (state_q == IDLE);
    assign busy      = !rst_n || (state_q != IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign char_code = char_q;

    // Out-of-range reads return a blank rather than aliasing onto another cell.
    always_comb begin
        char_d = 7'h20;
        if (XW'(rd_x) < COLS_X && {1'b0, rd_y} < ROWS_Y)
            char_d = mem_q[IW'(cell_addr(rd_y, XW'(rd_x)))];
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        col_d    = col_q;
        row_d    = row_q;
        row_ok_d = row_ok_q;
        seen_d   = seen_q;
        we       = 1'b0;
        waddr    = '0;
        wdata    = 7'h20;
        digit    = bcd_q[BCD_W-1 -: 4];
        blank    = 1'b0;
        bcd_adj  = bcd_q;
        for (int i = 0; i < DIGITS; i++)
            if (bcd_adj[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        2'b00: begin
                            we    = (XW'(cmd_x) < COLS_X) && ({1'b0, cmd_y} < ROWS_Y);
                            waddr = cell_addr(cmd_y, XW'(cmd_x));
                            wdata = cmd_char;
                        end
                        2'b01: begin
                            state_d  = CONV;
                            cnt_d    = '0;
                            bcd_d    = '0;
                            bin_d    = (32'(cmd_num) > MAX_NUM) ? NUM_W'(MAX_NUM) : cmd_num;
                            col_d    = XW'(cmd_x);
                            row_d    = cmd_y;
                            row_ok_d = {1'b0, cmd_y} < ROWS_Y;
                            seen_d   = 1'b0;
                        end
                        2'b10: begin
                            state_d = CLEAR;
                            addr_d  = '0;
                        end
                        default: ;
                    endcase
                end
            end
            CLEAR: begin
                we     = 1'b1;
                waddr  = addr_q;
                addr_d = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                    addr_d  = '0;
                end
            end
            // Double-dabble: add 3 to every BCD nibble >= 5, then shift one binary bit in.
            CONV: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NUM_W - 1)) begin
                    state_d = EMIT;
                    cnt_d   = '0;
                end
            end
            EMIT: begin
                blank  = (LEAD_BLANK != 0) && (digit == 4'd0) && !seen_q &&
                         (cnt_q != CNT_W'(DIGITS - 1));
                we     = row_ok_q && (col_q < COLS_X);
                waddr  = cell_addr(row_q, col_q);
                wdata  = blank ? 7'h20 : {3'b011, digit};
                seen_d = seen_q | (digit != 4'd0);
                bcd_d  = bcd_q << 4;
                col_d  = col_q + 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIGITS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        endcase

        if (!rst_n)
            we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= CLEAR;
            addr_q   <= '0;
            cnt_q    <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            row_ok_q <= 1'b0;
            seen_q   <= 1'b0;
            char_q   <= 7'h20;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            col_q    <= col_d;
            row_q    <= row_d;
            row_ok_q <= row_ok_d;
            seen_q   <= seen_d;
            char_q   <= char_d;
        end
    end

    // No reset on the array: the CLEAR sweep establishes its contents.
    always_ff @(posedge clk) begin
        if (we)
            mem_q[IW'(waddr)] <= wdata;
    end

endmodule

// File: tb/tb_txt_buffer.sv
// tb_txt_buffer: drives a 16x16 leading-blank instance and a 20x12 leading-zero instance
// and compares every screen read against a character-array model of each screen.
module tb_txt_buffer;
    localparam int C1 = 16, R1 = 16, C2 = 20, R2 = 12;
    localparam int BUSY_LIMIT = 2000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rdX, cmdX;
    logic [3:0] rdY, cmdY;
    logic [1:0] cmdOp;
    logic [6:0] cmdChar;
    logic [9:0] cmdNum;
    logic       valid1, valid2;
    logic       ready1, ready2, busy1, busy2;
    logic [6:0] char1, char2;

    int checks = 0;
    int fails  = 0;
    logic [6:0] model1 [C1*R1];
    logic [6:0] model2 [C2*R2];

    always #5 clk = ~clk;

    txt_buffer #(.COLS(C1), .ROWS(R1), .DIGITS(3), .NUM_W(10), .LEAD_BLANK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rd_x(rdX[3:0]), .rd_y(rdY), .char_code(char1),
        .cmd_valid(valid1), .cmd_ready(ready1), .cmd_op(cmdOp), .cmd_x(cmdX[3:0]),
        .cmd_y(cmdY), .cmd_char(cmdChar), .cmd_num(cmdNum), .busy(busy1));

    txt_buffer #(.COLS(C2), .ROWS(R2), .DIGITS(3), .NUM_W(10), .LEAD_BLANK(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .rd_x(rdX), .rd_y(rdY), .char_code(char2),
        .cmd_valid(valid2), .cmd_ready(ready2), .cmd_op(cmdOp), .cmd_x(cmdX),
        .cmd_y(cmdY), .cmd_char(cmdChar), .cmd_num(cmdNum), .busy(busy2));

    function automatic logic readyOf(int u);
        return (u == 1) ? ready1 : ready2;
    endfunction

    function automatic logic busyOf(int u);
        return (u == 1) ? busy1 : busy2;
    endfunction

    function automatic logic [6:0] charOf(int u);
        return (u == 1) ? char1 : char2;
    endfunction

    function automatic logic [6:0] modelAt(int u, int x, int y);
        if (u == 1) return (x < C1 && y < R1) ? model1[y*C1+x] : 7'h20;
        return (x < C2 && y < R2) ? model2[y*C2+x] : 7'h20;
    endfunction

    // Character printed at place i (0 = most significant) of a three-digit number.
    function automatic logic [6:0] digitChar(int v, int i, bit leadBlank);
        int place = 1;
        for (int k = i; k < 2; k++) place *= 10;
        if (leadBlank && i < 2 && v < place) return 7'h20;
        return 7'(48 + (v / place) % 10);
    endfunction

    function automatic int expectedBusy(int u, logic [1:0] op);
        if (op == 2'b01) return 13;
        if (op == 2'b10) return (u == 1) ? C1*R1 : C2*R2;
        return 0;
    endfunction

    task automatic modelPut(input int u, input int x, input int y, input logic [6:0] c);
        if (u == 1) begin
            if (x < C1 && y < R1) model1[y*C1+x] = c;
        end else if (x < C2 && y < R2) begin
            model2[y*C2+x] = c;
        end
    endtask

    task automatic modelClear(input int u);
        if (u == 1) foreach (model1[i]) model1[i] = 7'h20;
        else        foreach (model2[i]) model2[i] = 7'h20;
    endtask

    task automatic modelApply(input int u, input logic [1:0] op, input int x, input int y,
                              input logic [6:0] ch, input int num);
        int v;
        case (op)
            2'b00: modelPut(u, x, y, ch);
            2'b01: begin
                v = (num > 999) ? 999 : num;
                for (int i = 0; i < 3; i++) modelPut(u, x + i, y, digitChar(v, i, u == 1));
            end
            2'b10: modelClear(u);
            default: ;
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents a command at a negedge and holds it until the unit accepts it.
    task automatic applyStimulus(input int u, input logic [1:0] op, input int x, input int y,
                                 input logic [6:0] ch, input int num, output int waited);
        cmdOp = op; cmdX = 5'(x); cmdY = 4'(y); cmdChar = ch; cmdNum = 10'(num);
        if (u == 1) valid1 = 1'b1; else valid2 = 1'b1;
        waited = 0;
        while (!readyOf(u) && waited < BUSY_LIMIT) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("accept within limit", 32'(waited < BUSY_LIMIT), 32'd1);
        @(negedge clk);
        valid1 = 1'b0;
        valid2 = 1'b0;
    endtask

    task automatic waitIdle(input int u, output int n);
        n = 0;
        while (busyOf(u) && n < BUSY_LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic readCell(input int u, input int x, input int y, output logic [6:0] c);
        rdX = 5'(x); rdY = 4'(y);
        @(negedge clk);
        c = charOf(u);
    endtask

    task automatic checkScreen(input int u, input string tag);
        int bad = 0;
        int firstBad = -1;
        int xMax = (u == 1) ? 16 : 24;
        logic [6:0] got;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < xMax; x++) begin
                readCell(u, x, y, got);
                if (got !== modelAt(u, x, y)) begin
                    bad++;
                    if (firstBad < 0) firstBad = y*32 + x;
                end
            end
        checkOutput($sformatf("%s screen%0d bad cells (first y*32+x=%0d)", tag, u, firstBad),
                    32'(bad), 32'd0);
    endtask

    task automatic doCmd(input int u, input logic [1:0] op, input int x, input int y,
                         input logic [6:0] ch, input int num, input string tag);
        int w, n;
        applyStimulus(u, op, x, y, ch, num, w);
        checkOutput({tag, " ready after accept"}, 32'(readyOf(u)),
                    32'(op == 2'b00 || op == 2'b11));
        waitIdle(u, n);
        checkOutput({tag, " busy cycles"}, 32'(n), 32'(expectedBusy(u, op)));
        modelApply(u, op, x, y, ch, num);
        checkScreen(u, tag);
    endtask

    task automatic resetAll(input int lowCycles);
        int n1 = 0;
        int n2 = 0;
        rst_n = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
        repeat (lowCycles) @(negedge clk);
        checkOutput("reset char1", 32'(char1), 32'h20);
        checkOutput("reset busy1", 32'(busy1), 32'd1);
        checkOutput("reset ready1", 32'(ready1), 32'd0);
        checkOutput("reset char2", 32'(char2), 32'h20);
        checkOutput("reset ready2", 32'(ready2), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < BUSY_LIMIT; k++) begin
            if (!busy1 && !busy2) break;
            if (busy1) n1++;
            if (busy2) n2++;
            @(negedge clk);
        end
        checkOutput("sweep cycles 16x16", 32'(n1), 32'd256);
        checkOutput("sweep cycles 20x12", 32'(n2), 32'd240);
        checkOutput("ready after sweep", 32'(ready1), 32'd1);
        modelClear(1);
        modelClear(2);
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w, u, r, x, y;
        logic [1:0] op;
        logic [6:0] c;
        rst_n = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
        rdX = '0; rdY = '0; cmdX = '0; cmdY = '0; cmdOp = '0; cmdChar = '0; cmdNum = '0;

        resetAll(3);
        checkScreen(1, "after reset");
        checkScreen(2, "after reset");

        // Read-before-write on the accept edge, then the new character.
        rdX = 5'd5; rdY = 4'd0;
        applyStimulus(1, 2'b00, 5, 0, 7'h52, 0, w);
        checkOutput("same-cycle read old", 32'(char1), 32'h20);
        modelApply(1, 2'b00, 5, 0, 7'h52, 0);
        @(negedge clk);
        checkOutput("write visible", 32'(char1), 32'h52);
        checkOutput("ready after write", 32'(ready1), 32'd1);

        doCmd(1, 2'b01, 13, 1, 7'h00, 42, "print 42");
        readCell(1, 13, 1, c); checkOutput("42 col13", 32'(c), 32'h20);
        readCell(1, 14, 1, c); checkOutput("42 col14", 32'(c), 32'h34);
        readCell(1, 15, 1, c); checkOutput("42 col15", 32'(c), 32'h32);
        doCmd(1, 2'b01, 0, 3, 7'h00, 0, "print 0");
        readCell(1, 0, 3, c); checkOutput("0 col0", 32'(c), 32'h20);
        readCell(1, 1, 3, c); checkOutput("0 col1", 32'(c), 32'h20);
        readCell(1, 2, 3, c); checkOutput("0 col2", 32'(c), 32'h30);
        doCmd(1, 2'b01, 15, 2, 7'h00, 1023, "print 1023");
        readCell(1, 15, 2, c); checkOutput("sat col15", 32'(c), 32'h39);
        doCmd(1, 2'b01, 6, 9, 7'h00, 105, "print 105");

        doCmd(2, 2'b01, 0, 0, 7'h00, 7, "lz print 7");
        readCell(2, 0, 0, c); checkOutput("007 col0", 32'(c), 32'h30);
        readCell(2, 1, 0, c); checkOutput("007 col1", 32'(c), 32'h30);
        readCell(2, 2, 0, c); checkOutput("007 col2", 32'(c), 32'h37);
        doCmd(2, 2'b01, 18, 4, 7'h00, 256, "lz print edge");
        doCmd(2, 2'b01, 0, 12, 7'h00, 555, "print bad row");
        doCmd(2, 2'b00, 21, 0, 7'h58, 0, "write bad col");
        doCmd(2, 2'b00, 3, 12, 7'h59, 0, "write bad row");
        doCmd(2, 2'b00, 19, 11, 7'h5A, 0, "write corner");

        // Reset pulse in the middle of a conversion discards the print.
        applyStimulus(1, 2'b01, 4, 5, 7'h00, 123, w);
        repeat (3) @(negedge clk);
        resetAll(1);
        checkScreen(1, "reset in conv");
        readCell(1, 5, 5, c); checkOutput("discarded digit", 32'(c), 32'h20);

        // A command held through a clear sweep is taken as soon as ready rises.
        applyStimulus(1, 2'b10, 0, 0, 7'h00, 0, w);
        checkOutput("clear accept wait", 32'(w), 32'd0);
        modelApply(1, 2'b10, 0, 0, 7'h00, 0);
        applyStimulus(1, 2'b00, 3, 7, 7'h41, 0, w);
        checkOutput("held cmd wait", 32'(w), 32'd256);
        checkOutput("held cmd busy", 32'(busy1), 32'd0);
        modelApply(1, 2'b00, 3, 7, 7'h41, 0);
        checkScreen(1, "held cmd");
        doCmd(1, 2'b11, 8, 8, 7'h4E, 77, "no-op");
        doCmd(2, 2'b10, 0, 0, 7'h00, 0, "clear 20x12");

        for (int k = 0; k < 24; k++) begin
            u = int'($urandom_range(1, 2));
            r = int'($urandom_range(0, 9));
            op = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b11 : 2'b10;
            x = (u == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 23));
            y = int'($urandom_range(0, 15));
            doCmd(u, op, x, y, 7'($urandom_range(33, 126)), int'($urandom_range(0, 1023)),
                  $sformatf("random %0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
